argon_sequencer: RTL and testbench

Micro-sequencer that drives the Argon datapath bus protocol from the controlling side. It accepts one decoded register-register ALU instruction per valid/ready handshake. It then walks the ALU and register file through the fixed strobe sequence: select registers, load A, load B, load op, write back, and optionally read flags. It sits where the testbench currently pokes the control wires, and it shares the datapath's 16-bit bus with the ALU and register file.

---
 rtl/argon_sequencer.sv | 144 ++++++++++++++
 tb/tb_argon_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/argon_sequencer.sv
// argon_sequencer: issues one register-register ALU instruction per handshake by
// stepping the Argon regfile/ALU strobes through SEL, LDA, LDB, OP, WB and optional FLG.
module argon_sequencer #(
  parameter int REG_SEL_W = 4,
  parameter int OP_W      = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [OP_W-1:0]      i_op,
  input  logic [REG_SEL_W-1:0] i_ra,
  input  logic [REG_SEL_W-1:0] i_rb,
  input  logic [REG_SEL_W-1:0] i_rc,
  input  logic                 i_want_flags,
  input  logic [15:0]          i_bus,
  input  logic                 i_bus_valid,
  output logic [15:0]          o_bus,
  output logic                 o_bus_valid,
  output logic                 o_selectLatch,
  output logic                 o_outputA,
  output logic                 o_outputB,
  output logic                 o_latchC,
  output logic                 o_latchA,
  output logic                 o_latchB,
  output logic                 o_latchOp,
  output logic                 o_outputY,
  output logic                 o_outputF,
  output logic                 o_done,
  output logic [15:0]          o_flags,
  output logic                 o_fault,
  input  logic                 i_clear_fault
);

  typedef enum logic [2:0] {IDLE, SEL, LDA, LDB, OP, WB, FLG} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic              want_flags_q;
  logic              accept;
  logic              fault_set;
  logic [15:0]       sel_word;
  logic [15:0]       op_word;

  logic              ready_q;
  logic              sel_q, lda_q, ldb_q, op_strobe_q, wb_q, flg_q;
  logic              bus_valid_q;
  logic [15:0]       bus_q;
  logic              done_q;
  logic [15:0]       flags_q;
  logic              fault_q;

  assign accept = (state_q == IDLE) && i_valid;

  // Selector word is built from the live inputs because it is only needed on the accept edge.
  always_comb begin
    sel_word = '0;
    sel_word[3*REG_SEL_W-1:0] = {i_rc, i_rb, i_ra};
    op_word = '0;
    op_word[OP_W-1:0] = op_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = SEL;
      SEL:     state_d = LDA;
      LDA:     state_d = LDB;
      LDB:     state_d = OP;
      OP:      state_d = WB;
      WB:      state_d = want_flags_q ? FLG : IDLE;
      FLG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read steps expect a datapath driver; drive steps expect the bus to be free.
  always_comb begin
    case (state_q)
      LDA, LDB, WB, FLG: fault_set = !i_bus_valid;
      SEL, OP:           fault_set = i_bus_valid;
      default:           fault_set = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      want_flags_q <= 1'b0;
      ready_q      <= 1'b1;
      sel_q        <= 1'b0;
      lda_q        <= 1'b0;
      ldb_q        <= 1'b0;
      op_strobe_q  <= 1'b0;
      wb_q         <= 1'b0;
      flg_q        <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_q        <= '0;
      done_q       <= 1'b0;
      flags_q      <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q         <= i_op;
        want_flags_q <= i_want_flags;
      end
      // Outputs are registered from the next state so they line up with state_q.
      ready_q     <= (state_d == IDLE);
      sel_q       <= (state_d == SEL);
      lda_q       <= (state_d == LDA);
      ldb_q       <= (state_d == LDB);
      op_strobe_q <= (state_d == OP);
      wb_q        <= (state_d == WB);
      flg_q       <= (state_d == FLG);
      bus_valid_q <= (state_d == SEL) || (state_d == OP);
      done_q      <= ((state_d == WB) && !want_flags_q) || (state_d == FLG);
      if (state_d == SEL)     bus_q <= sel_word;
      else if (state_d == OP) bus_q <= op_word;
      else                    bus_q <= '0;
      if (state_q == FLG) flags_q <= i_bus;
      if (fault_set)          fault_q <= 1'b1;
      else if (i_clear_fault) fault_q <= 1'b0;
    end
  end

  assign o_ready       = ready_q;
  assign o_selectLatch = sel_q;
  assign o_outputA     = lda_q;
  assign o_latchA      = lda_q;
  assign o_outputB     = ldb_q;
  assign o_latchB      = ldb_q;
  assign o_latchOp     = op_strobe_q;
  assign o_outputY     = wb_q;
  assign o_latchC      = wb_q;
  assign o_outputF     = flg_q;
  assign o_bus         = bus_q;
  assign o_bus_valid   = bus_valid_q;
  assign o_done        = done_q;
  assign o_flags       = flags_q;
  assign o_fault       = fault_q;

endmodule

// File: tb/tb_argon_sequencer.sv
// Scoreboard bench for argon_sequencer: stimulus pushes expected instructions,
// a negedge monitor replays each against a step table and a protocol fault model.
module tb_argon_sequencer;
  localparam int W   = 4;
  localparam int OPW = 4;

  logic            clk = 1'b0;
  logic            i_Reset, i_valid, i_want_flags, i_clear_fault;
  logic [OPW-1:0]  i_op;
  logic [W-1:0]    i_ra, i_rb, i_rc;
  logic [15:0]     i_bus;
  logic            i_bus_valid;
  logic            o_ready, o_bus_valid, o_done, o_fault;
  logic [15:0]     o_bus, o_flags;
  logic            o_selectLatch, o_outputA, o_outputB, o_latchC;
  logic            o_latchA, o_latchB, o_latchOp, o_outputY, o_outputF;

  always #5 clk = ~clk;

  argon_sequencer #(.REG_SEL_W(W), .OP_W(OPW)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_ra(i_ra), .i_rb(i_rb), .i_rc(i_rc), .i_want_flags(i_want_flags),
    .i_bus(i_bus), .i_bus_valid(i_bus_valid), .o_bus(o_bus), .o_bus_valid(o_bus_valid),
    .o_selectLatch(o_selectLatch), .o_outputA(o_outputA), .o_outputB(o_outputB),
    .o_latchC(o_latchC), .o_latchA(o_latchA), .o_latchB(o_latchB), .o_latchOp(o_latchOp),
    .o_outputY(o_outputY), .o_outputF(o_outputF), .o_done(o_done), .o_flags(o_flags),
    .o_fault(o_fault), .i_clear_fault(i_clear_fault)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0, drop_ldb = 0, contend_sel = 0, fixed_flags = 0;

  // Datapath model: units answer read strobes; fault knobs break the protocol on purpose.
  assign i_bus_valid = ((o_outputA | o_outputB | o_outputY | o_outputF) && !(drop_ldb && o_latchB))
                       || (contend_sel && o_selectLatch);
  assign i_bus = !i_bus_valid ? 16'h0000 :
                 (o_outputF && fixed_flags) ? 16'h0004 : (cyc[15:0] ^ 16'hA5C3);

  typedef struct {
    logic [15:0] sel_word;
    logic [15:0] op_word;
    bit          wf;
    int unsigned accept_cyc;
  } instr_t;
  instr_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle %0d", name, cyc);
  endtask

  function automatic logic [15:0] sel_of(input logic [W-1:0] ra, rb, rc);
    return (16'(rc) << (2*W)) | (16'(rb) << W) | 16'(ra);
  endfunction

  // Expected outputs per step: -1 idle, 0 SEL, 1 LDA, 2 LDB, 3 OP, 4 WB, 5 FLG.
  function automatic logic [27:0] exp_vec(input int step, input instr_t c);
    logic r, sl, oa, ob, lc, la, lb, lo, oy, of, bv, dn;
    logic [15:0] b;
    {r, sl, oa, ob, lc, la, lb, lo, oy, of, bv, dn} = '0;
    b = '0;
    case (step)
      0:       begin sl = 1; bv = 1; b = c.sel_word; end
      1:       begin oa = 1; la = 1; end
      2:       begin ob = 1; lb = 1; end
      3:       begin lo = 1; bv = 1; b = c.op_word; end
      4:       begin oy = 1; lc = 1; dn = !c.wf; end
      5:       begin of = 1; dn = 1; end
      default: r = 1;
    endcase
    return {r, sl, oa, ob, lc, la, lb, lo, oy, of, bv, dn, b};
  endfunction

  int          step = -1;
  instr_t      cur;
  bit          exp_fault = 0;
  logic [15:0] exp_flags = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit set_f;
      logic [27:0] act;
      if (step < 0) begin
        if (o_selectLatch) begin
          if (sbq.size() == 0) fail_event("start_without_accept");
          else begin
            cur = sbq.pop_front();
            check("sel_latency", 64'(cyc), 64'(cur.accept_cyc));
            step = 0;
          end
        end else if (sbq.size() != 0 && cyc >= sbq[0].accept_cyc) begin
          fail_event("missing_start");
          void'(sbq.pop_front());
        end
      end
      act = {o_ready, o_selectLatch, o_outputA, o_outputB, o_latchC, o_latchA, o_latchB,
             o_latchOp, o_outputY, o_outputF, o_bus_valid, o_done, o_bus};
      check($sformatf("outputs_step%0d", step), 64'(act), 64'(exp_vec(step, cur)));
      check("fault", 64'(o_fault), 64'(exp_fault));
      check("flags", 64'(o_flags), 64'(exp_flags));
      set_f = 0;
      case (step)
        1, 2, 4, 5: set_f = !i_bus_valid;
        0, 3:       set_f = i_bus_valid;
        default:    set_f = 0;
      endcase
      if (set_f) exp_fault = 1;
      else if (i_clear_fault) exp_fault = 0;
      if (step == 5) exp_flags = i_bus;
      if ((step == 4 && !cur.wf) || step == 5)
        $display("txn sel=%h op=%h wf=%0d accept=%0d", cur.sel_word, cur.op_word, cur.wf, cur.accept_cyc);
      case (step)
        0, 1, 2, 3: step = step + 1;
        4:          step = cur.wf ? 5 : -1;
        5:          step = -1;
        default:    step = -1;
      endcase
      if (i_Reset) begin
        step = -1;
        exp_fault = 0;
        exp_flags = '0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (!i_valid) begin
        i_op = OPW'($urandom); i_ra = W'($urandom); i_rb = W'($urandom); i_rc = W'($urandom);
        i_want_flags = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic send(input logic [OPW-1:0] op, input logic [W-1:0] ra, rb, rc,
                      input bit wf, output int unsigned acc);
    int waited = 0;
    i_op = op; i_ra = ra; i_rb = rb; i_rc = rc; i_want_flags = wf; i_valid = 1;
    while (!o_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    acc = 0;
    if (!o_ready) begin
      fail_event("accept_timeout");
      i_valid = 0;
    end else begin
      acc = cyc + 1;
      sbq.push_back('{sel_word: sel_of(ra, rb, rc), op_word: 16'(op), wf: wf, accept_cyc: acc});
      @(posedge clk); #1;
      i_valid = 0;
      i_op = OPW'($urandom); i_ra = W'($urandom); i_rb = W'($urandom); i_rc = W'($urandom);
      i_want_flags = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int unsigned a0, a1;
    int k;
    i_Reset = 1; i_valid = 0; i_clear_fault = 0;
    i_op = '0; i_ra = '0; i_rb = '0; i_rc = '0; i_want_flags = 0;
    repeat (3) @(posedge clk);
    #1;
    i_Reset = 0;
    mon_en = 1;
    cycles(10);

    // Single ADD without flags.
    send(4'd3, 4'd1, 4'd2, 4'd5, 0, a0);
    check("add_sel_word", 64'(o_bus), 64'(16'h0521));
    cycles(3);
    check("add_op_word", 64'(o_bus), 64'(16'h0003));
    cycles(1);
    check("add_done_wb", 64'(o_done), 64'(1'b1));
    cycles(1);
    check("add_ready_back", 64'(o_ready), 64'(1'b1));
    check("add_no_fault", 64'(o_fault), 64'(1'b0));
    cycles(2);

    // Same instruction with flag readback.
    fixed_flags = 1;
    send(4'd3, 4'd1, 4'd2, 4'd5, 1, a0);
    cycles(4);
    check("flg_no_done_wb", 64'(o_done), 64'(1'b0));
    cycles(1);
    check("flg_done", 64'(o_done), 64'(1'b1));
    cycles(1);
    check("flg_value", 64'(o_flags), 64'(16'h0004));
    fixed_flags = 0;
    cycles(2);

    // Back-to-back with valid held.
    send(4'd6, 4'd3, 4'd4, 4'd1, 0, a0);
    send(4'd2, 4'd7, 4'd8, 4'd9, 0, a1);
    check("b2b_sel_word", 64'(o_bus), 64'(16'h0987));
    check("b2b_spacing", 64'(a1 - a0), 64'd6);
    send(4'd1, 4'd2, 4'd3, 4'd4, 1, a0);
    send(4'd5, 4'd6, 4'd7, 4'd8, 0, a1);
    check("b2b_spacing_flags", 64'(a1 - a0), 64'd7);
    cycles(6);

    // Missing driver in LDB.
    drop_ldb = 1;
    send(4'd3, 4'd1, 4'd2, 4'd5, 0, a0);
    cycles(2);
    check("drop_no_fault_yet", 64'(o_fault), 64'(1'b0));
    cycles(1);
    check("drop_fault_set", 64'(o_fault), 64'(1'b1));
    drop_ldb = 0;
    cycles(3);
    i_clear_fault = 1;
    cycles(1);
    i_clear_fault = 0;
    check("fault_cleared", 64'(o_fault), 64'(1'b0));

    // Contention in SEL, then set beating a simultaneous clear.
    contend_sel = 1;
    send(4'd9, 4'd2, 4'd2, 4'd2, 0, a0);
    cycles(1);
    check("contend_fault", 64'(o_fault), 64'(1'b1));
    contend_sel = 0;
    cycles(5);
    i_clear_fault = 1;
    contend_sel = 1;
    send(4'd9, 4'd3, 4'd3, 4'd3, 0, a0);
    cycles(1);
    check("set_wins_clear", 64'(o_fault), 64'(1'b1));
    cycles(1);
    check("clear_after_set", 64'(o_fault), 64'(1'b0));
    i_clear_fault = 0;
    contend_sel = 0;
    cycles(5);

    // Reset in LDB drops the instruction.
    send(4'd3, 4'd1, 4'd2, 4'd5, 1, a0);
    cycles(2);
    i_Reset = 1;
    cycles(1);
    i_Reset = 0;
    check("rst_ready", 64'(o_ready), 64'(1'b1));
    check("rst_flags", 64'(o_flags), 64'(16'h0000));
    check("rst_no_done", 64'(o_done), 64'(1'b0));
    cycles(3);
    send(4'd4, 4'd5, 4'd6, 4'd7, 0, a0);
    cycles(6);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      send(OPW'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), a0);
      cycles($urandom_range(0, 3));
    end

    k = 0;
    while ((sbq.size() != 0 || step >= 0) && k < 200) begin
      cycles(1);
      k++;
    end
    if (k >= 200) fail_event("drain_timeout");
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
